car_link_responder: RTL and testbench

Car-side end of the command/status serial link: receives the 8-bit command byte framed as header 2'b10 plus {destroy_barrier, place_barrier, turn_right, turn_left, move_backward, move_forward}, decodes and holds it, and returns the 4-bit detector status byte. Sits between the car model (or board stub) and the UART pins, opposite the driving-control device. 8N1, LSB first, idle high.

---
 rtl/car_link_pkg.sv | 20 ++
 rtl/car_link_uart_rx.sv | 70 +++++++
 rtl/car_link_responder.sv | 102 ++++++++++
 tb/tb_car_link_responder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/car_link_pkg.sv
// car_link_pkg: shared link constants, command bit indices and FSM state types
//   CMD_HDR / STS_HDR : frame headers for command and status bytes
//   FWD..DESTROY      : bit positions inside the 6-bit command field
//   rx_state_t        : receiver states
//   tx_state_t        : status transmitter states
package car_link_pkg;
   localparam logic [1:0] CMD_HDR = 2'b10;
   localparam logic [1:0] STS_HDR = 2'b01;
   localparam int FWD     = 0;
   localparam int BACK    = 1;
   localparam int LEFT    = 2;
   localparam int RIGHT   = 3;
   localparam int PLACE   = 4;
   localparam int DESTROY = 5;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   function automatic logic [7:0] status_byte(input logic [3:0] det);
      return {STS_HDR, 2'b00, det};
   endfunction
endpackage

// File: rtl/car_link_uart_rx.sv
// car_link_uart_rx: 8N1 LSB-first receiver with input synchronizer
//   sys_clk, rst_n : clock, synchronous active-low reset
//   rx             : asynchronous serial input, idle high
//   data           : last received byte (meaningful when valid pulses)
//   valid          : one-cycle pulse, byte received with good stop bit
//   frame_err      : one-cycle pulse, stop bit sampled low
module car_link_uart_rx import car_link_pkg::*; #(
   parameter int CLKS_PER_BIT = 10417
) (
   input  logic       sys_clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   // sync[1] is the synchronized line, sync[2] its previous value for edge detect
   logic [2:0] sync;
   rx_state_t state;
   logic [CW-1:0] cnt;
   logic [2:0] idx;
   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         sync      <= 3'b111;
         state     <= RX_IDLE;
         cnt       <= '0;
         idx       <= '0;
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         sync      <= {sync[1:0], rx};
         valid     <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            RX_IDLE: begin
               cnt <= '0;
               if (sync[2] && !sync[1]) state <= RX_START;
            end
            // half a bit in: still low means a real start bit, high means a glitch
            RX_START:
               if (cnt == HALF) begin
                  cnt   <= '0;
                  idx   <= '0;
                  state <= sync[1] ? RX_IDLE : RX_DATA;
               end else cnt <= cnt + 1'b1;
            RX_DATA:
               if (cnt == FULL) begin
                  cnt  <= '0;
                  data <= {sync[1], data[7:1]};
                  idx  <= idx + 1'b1;
                  if (idx == 3'd7) state <= RX_STOP;
               end else cnt <= cnt + 1'b1;
            // return to idle at stop centre so a back-to-back start edge is caught
            RX_STOP:
               if (cnt == FULL) begin
                  cnt       <= '0;
                  valid     <= sync[1];
                  frame_err <= !sync[1];
                  state     <= sync[1] ? RX_IDLE : RX_WAIT_HIGH;
               end else cnt <= cnt + 1'b1;
            RX_WAIT_HIGH: if (sync[1]) state <= RX_IDLE;
            default: state <= RX_IDLE;
         endcase
      end
   end
endmodule

// File: rtl/car_link_responder.sv
// car_link_responder: car-side command receiver/decoder and status transmitter
//   sys_clk, rst_n : clock, synchronous active-low reset
//   rx             : serial command line from the device
//   tx             : serial status line to the device (registered)
//   detector       : {right, left, back, front} obstacle flags
//   cmd            : last accepted {destroy, place, right, left, back, forward}
//   cmd_valid      : one-cycle pulse when cmd updates
//   frame_err      : one-cycle pulse, command stop bit low
//   header_err     : one-cycle pulse, command header not 2'b10
module car_link_responder import car_link_pkg::*; #(
   parameter int CLKS_PER_BIT  = 10417,
   parameter int STATUS_PERIOD = 1000000
) (
   input  logic       sys_clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic       tx,
   input  logic [3:0] detector,
   output logic [5:0] cmd,
   output logic       cmd_valid,
   output logic       frame_err,
   output logic       header_err
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int TW = $clog2(STATUS_PERIOD);
   logic [7:0] rx_byte;
   logic rx_valid, rx_ferr;
   tx_state_t state;
   logic [CW-1:0] cnt;
   logic [2:0] idx;
   logic [7:0] sh;
   logic [3:0] last;
   logic pend;
   logic [TW-1:0] timer;
   logic tick, trig, bit_end, go;
   car_link_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .sys_clk  (sys_clk),
      .rst_n    (rst_n),
      .rx       (rx),
      .data     (rx_byte),
      .valid    (rx_valid),
      .frame_err(rx_ferr)
   );
   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         cmd        <= '0;
         cmd_valid  <= 1'b0;
         frame_err  <= 1'b0;
         header_err <= 1'b0;
      end else begin
         cmd_valid  <= rx_valid && rx_byte[7:6] == CMD_HDR;
         header_err <= rx_valid && rx_byte[7:6] != CMD_HDR;
         frame_err  <= rx_ferr;
         if (rx_valid && rx_byte[7:6] == CMD_HDR) cmd <= rx_byte[DESTROY:FWD];
      end
   end
   // a frame may start when idle or straight out of the last stop-bit cycle
   always_comb begin
      tick    = timer == TW'(STATUS_PERIOD - 1);
      trig    = tick || detector != last;
      bit_end = cnt == CW'(CLKS_PER_BIT - 1);
      go      = (trig || pend) && (state == TX_IDLE || (state == TX_STOP && bit_end));
   end
   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         state <= TX_IDLE;
         cnt   <= '0;
         idx   <= '0;
         sh    <= '0;
         last  <= '0;
         pend  <= 1'b0;
         timer <= '0;
         tx    <= 1'b1;
      end else begin
         timer <= tick ? '0 : timer + 1'b1;
         pend  <= !go && (pend || trig);
         cnt   <= (go || bit_end || state == TX_IDLE) ? '0 : cnt + 1'b1;
         if (go) begin
            state <= TX_START;
            sh    <= status_byte(detector);
            last  <= detector;
            tx    <= 1'b0;
         end else if (bit_end) begin
            case (state)
               TX_START: begin
                  state <= TX_DATA;
                  idx   <= '0;
                  tx    <= sh[0];
                  sh    <= sh >> 1;
               end
               TX_DATA: begin
                  idx <= idx + 1'b1;
                  sh  <= sh >> 1;
                  tx  <= (idx == 3'd7) ? 1'b1 : sh[0];
                  if (idx == 3'd7) state <= TX_STOP;
               end
               default: state <= TX_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_car_link_responder.sv
// tb_car_link_responder: randomized self-checking bench with frame-level reference model
module tb_car_link_responder;
   localparam int CPB = 16;
   localparam int PER = 400;
   logic sys_clk = 0, rst_n = 0, rx = 1;
   logic [3:0] detector = 0;
   logic tx, cmd_valid, frame_err, header_err;
   logic [5:0] cmd;
   int n_checks = 0, n_fail = 0;
   int n_cv = 0, n_fe = 0, n_he = 0, e_cv = 0, e_fe = 0, e_he = 0;
   logic [5:0] e_cmd = 0;
   int t = 0, fs = -1, dk = -1, starts = 0;
   bit pend_m = 0, trig_m;
   logic [3:0] last_m = 0;
   logic [7:0] fb = 0, db = 0;
   logic exp_tx = 1;
   logic [7:0] txq[$];

   car_link_responder #(.CLKS_PER_BIT(CPB), .STATUS_PERIOD(PER)) dut (
      .sys_clk(sys_clk), .rst_n(rst_n), .rx(rx), .tx(tx), .detector(detector),
      .cmd(cmd), .cmd_valid(cmd_valid), .frame_err(frame_err), .header_err(header_err)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   function automatic logic frame_bit(input logic [7:0] b, input int i);
      return i == 0 ? 1'b0 : i >= 9 ? 1'b1 : b[i-1];
   endfunction

   // status link model: a frame spans 10*CPB cycles; triggers while busy collapse into one pending start
   always @(posedge sys_clk) begin
      if (!rst_n) begin
         t = 0; fs = -1; pend_m = 0; last_m = 0;
      end else begin
         trig_m = (t % PER == PER - 1) || (detector != last_m);
         if ((fs < 0 || t >= fs + 10*CPB - 1) && (trig_m || pend_m)) begin
            fs = t + 1; fb = {2'b01, 2'b00, detector}; last_m = detector; pend_m = 0;
         end else pend_m = pend_m | trig_m;
         t++;
      end
      exp_tx = (fs >= 0 && t - fs < 10*CPB) ? frame_bit(fb, (t - fs) / CPB) : 1'b1;
   end

   // per-cycle tx comparison, pulse counting and a tx frame decoder
   always @(negedge sys_clk) begin
      check("tx", tx, exp_tx);
      n_cv += int'(cmd_valid);
      n_fe += int'(frame_err);
      n_he += int'(header_err);
      if (!rst_n) begin
         if (dk >= 0) txq.push_back(8'h00);
         dk = -1;
      end else if (dk < 0) begin
         if (tx === 1'b0) begin dk = 0; starts++; end
      end else begin
         dk++;
         if (dk % CPB == CPB/2 && dk > CPB && dk < 9*CPB) db[dk/CPB - 1] = tx;
         if (dk == 9*CPB + CPB/2) begin txq.push_back(db); dk = -1; end
      end
   end

   task automatic send(input logic [7:0] b, input logic stop);
      for (int i = 0; i < 10; i++) begin
         rx = (i == 0) ? 1'b0 : (i == 9) ? stop : b[i-1];
         tick(CPB);
      end
      rx = 1'b1;
   endtask

   task automatic rx_check(input string tag);
      check({tag, "_cv"}, n_cv, e_cv);
      check({tag, "_fe"}, n_fe, e_fe);
      check({tag, "_he"}, n_he, e_he);
      check({tag, "_cmd"}, cmd, e_cmd);
   endtask

   task automatic rx_byte(input string tag, input logic [7:0] b, input logic stop, input int gap);
      send(b, stop);
      if (!stop) e_fe++;
      else if (b[7:6] == 2'b10) begin e_cv++; e_cmd = b[5:0]; end
      else e_he++;
      if (gap > 0) begin
         tick(gap);
         rx_check(tag);
      end
   endtask

   task automatic wait_start(input string tag, input int budget, output int idx);
      int s0 = starts;
      int n = 0;
      while (starts == s0 && n < budget) begin tick(1); n++; end
      check(tag, starts > s0, 1);
      idx = starts - 1;
   endtask

   task automatic wait_q(input string tag, input int cnt, input int budget);
      int n = 0;
      while (txq.size() < cnt && n < budget) begin tick(1); n++; end
      check(tag, txq.size() >= cnt, 1);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int n, i1, i2, i3;
      logic [7:0] b;
      logic stop;
      tick(5);
      rst_n = 1;
      check("rst_tx", tx, 1);
      check("rst_cmd", cmd, 0);
      check("rst_cv", cmd_valid, 0);
      check("rst_fe", frame_err, 0);
      check("rst_he", header_err, 0);
      n = 0;
      while (tx !== 1'b0 && n < 500) begin tick(1); n++; end
      check("first_status_cycle", n, PER);
      wait_q("first_status_rx", 1, 300);
      check("first_status_byte", txq[0], 8'h40);

      rx_byte("a5", 8'hA5, 1, 4);
      check("a5_cmd_bits", cmd, 6'b100101);
      rx_byte("hdr45", 8'h45, 1, 4);
      rx_byte("stop0", 8'hA1, 0, CPB);
      rx_byte("after_ferr", 8'h83, 1, 4);
      check("83_cmd_bits", cmd, 6'b000011);
      rx_byte("b2b_first", 8'hBF, 1, 0);
      rx_byte("b2b_second", 8'h9C, 1, 4);

      rx = 0; tick(8); rx = 1; tick(40);
      rx_check("glitch");

      wait_start("det_f1_start", 600, i1);
      tick(40);
      detector = 4'b0101;
      wait_start("det_f2_start", 300, i2);
      check("det_f2_follows", i2, i1 + 1);
      tick(20); detector = 4'b0110;
      tick(20); detector = 4'b1001;
      tick(20); detector = 4'b1000;
      wait_q("det_f3_rx", i2 + 2, 600);
      check("det_f2_byte", txq[i2], 8'h45);
      check("det_f3_byte", txq[i2 + 1], 8'h48);

      wait_start("rst_tx_start", 600, i3);
      tick(50);
      rst_n = 0;
      tick(1);
      check("midtx_rst_tx", tx, 1);
      check("midtx_rst_cmd", cmd, 0);
      e_cmd = 0;
      tick(2);
      rst_n = 1;
      tick(2);

      fork
         begin
            repeat (30) begin
               b = 8'($urandom);
               if ($urandom_range(1, 0) == 1) b[7:6] = 2'b10;
               stop = $urandom_range(4, 0) != 0;
               rx_byte("rand", b, stop, stop ? int'($urandom_range(3, 0)) : CPB);
            end
            tick(4);
            rx_check("rand_end");
         end
         begin
            repeat (25) begin
               tick(int'($urandom_range(300, 30)));
               detector = 4'($urandom);
            end
         end
      join
      tick(200);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
